btb_ctrl: RTL and testbench

Branch-prediction control for the five-stage core: it carries each fetch's BTB prediction down to EX and compares it with the resolved outcome. On a mismatch it redirects fetch and squashes the younger instructions. It also owns the BTB write port, for both updates and the post-reset clear sweep. It sits between the fetch-stage BTB lookup, the EX-stage branch unit, and the hazard unit, and replaces ad-hoc BTB writes and reset-time table clearing.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bp_perf_cnt.sv | 18 +
 rtl/btb_ctrl.sv | 155 +++++++++++++++
 tb/tb_btb_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and sizing for branch-prediction control and the BTB write port.
package bp_pkg;

  localparam int unsigned BP_BITS = 5;
  localparam int unsigned ENTRIES = 1 << BP_BITS;
  localparam int unsigned XLEN    = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Legacy-compatible state encodings used by the FSM registers.
  localparam logic [0:0] ST_INIT = 1'(INIT);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

  // Prediction metadata carried alongside an instruction from IF to EX.
  typedef struct packed {
    logic            v;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } bp_meta_t;

  // One BTB write request.
  typedef struct packed {
    logic               we;
    logic [BP_BITS-1:0] idx;
    logic [XLEN-1:0]    tag;
    logic [XLEN-1:0]    target;
    logic               state;
  } btb_wr_t;

endpackage

// File: rtl/bp_perf_cnt.sv
// 32-bit saturating event counter with synchronous clear.
module bp_perf_cnt (
  input  logic        clk,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] cnt
);

  // Count events, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/btb_ctrl.sv
// Carries BTB predictions to EX, resolves them, redirects fetch on a miss and
// owns the BTB write port including the post-reset clear sweep.
module btb_ctrl
  import bp_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               if_valid,
  input  logic               if_pred_taken,
  input  logic [31:0]        if_pred_target,
  input  logic               id_stall,
  input  logic               ex_stall,
  input  logic               ex_valid,
  input  logic               ex_is_branch,
  input  logic               ex_br_taken,
  input  logic [31:0]        ex_pc,
  input  logic [31:0]        ex_br_target,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc,
  output logic               busy,
  output logic               btb_we,
  output logic [BP_BITS-1:0] btb_idx,
  output logic [31:0]        btb_tag,
  output logic [31:0]        btb_target,
  output logic               btb_state,
  output logic [31:0]        br_cnt,
  output logic [31:0]        miss_cnt
);

  localparam logic [BP_BITS-1:0] LAST_IDX = BP_BITS'(ENTRIES - 1);

  logic [0:0]         state_q, state_d;
  logic [BP_BITS-1:0] sweep_q, sweep_d;
  logic               busy_q, busy_d;
  bp_meta_t           id_meta_q, id_meta_d;
  bp_meta_t           ex_meta_q, ex_meta_d;
  btb_wr_t            wr_q, wr_d;

  logic               resolve;
  logic               br_res;
  logic               alias_hit;
  logic               mispredict;
  logic [31:0]        pc_plus4;
  logic [31:0]        actual_npc;

  // State, sweep, metadata pipeline and registered BTB write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      sweep_q   <= '0;
      busy_q    <= 1'b1;
      id_meta_q <= '0;
      ex_meta_q <= '0;
      wr_q      <= '{we: 1'b1, idx: '0, tag: '0, target: '0, state: 1'b0};
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      busy_q    <= busy_d;
      id_meta_q <= id_meta_d;
      ex_meta_q <= ex_meta_d;
      wr_q      <= wr_d;
    end
  end

  // Resolution, redirect, metadata advance and next FSM/write state.
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    busy_d     = busy_q;
    id_meta_d  = id_meta_q;
    ex_meta_d  = ex_meta_q;
    wr_d       = '0;
    mispredict = 1'b0;
    actual_npc = '0;
    pc_plus4   = ex_pc + 32'd4;

    resolve   = (state_q == ST_RUN) && ex_valid && ex_meta_q.v && !ex_stall;
    br_res    = resolve && ex_is_branch;
    alias_hit = resolve && !ex_is_branch && ex_meta_q.pred_taken;

    if (br_res) begin
      mispredict = (ex_meta_q.pred_taken != ex_br_taken) ||
                   (ex_br_taken && (ex_meta_q.pred_target != ex_br_target));
      actual_npc = ex_br_taken ? ex_br_target : pc_plus4;
    end else if (alias_hit) begin
      mispredict = 1'b1;
      actual_npc = pc_plus4;
    end

    // A redirect squashes both stages; otherwise EX stall beats ID stall.
    if (mispredict) begin
      id_meta_d = '0;
      ex_meta_d = '0;
    end else if (ex_stall) begin
      id_meta_d = id_meta_q;
      ex_meta_d = ex_meta_q;
    end else if (id_stall) begin
      ex_meta_d = '0;
    end else begin
      id_meta_d = '{v: if_valid, pred_taken: if_pred_taken, pred_target: if_pred_target};
      ex_meta_d = id_meta_q;
    end

    case (state_q)
      ST_INIT: begin
        if (sweep_q == LAST_IDX) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end else begin
          sweep_d = sweep_q + BP_BITS'(1);
          busy_d  = 1'b1;
          wr_d    = '{we: 1'b1, idx: sweep_q + BP_BITS'(1), tag: '0, target: '0, state: 1'b0};
        end
      end
      ST_RUN: begin
        busy_d = 1'b0;
        if (br_res) begin
          wr_d = '{we: 1'b1, idx: ex_pc[BP_BITS+1:2], tag: ex_pc,
                   target: ex_br_target, state: ex_br_taken};
        end else if (alias_hit) begin
          wr_d = '{we: 1'b1, idx: ex_pc[BP_BITS+1:2], tag: '0, target: '0, state: 1'b0};
        end
      end
      default: begin
        state_d = ST_INIT;
        sweep_d = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  assign redirect_valid = mispredict;
  assign redirect_pc    = mispredict ? actual_npc : '0;
  assign busy           = busy_q;
  assign btb_we         = wr_q.we;
  assign btb_idx        = wr_q.idx;
  assign btb_tag        = wr_q.tag;
  assign btb_target     = wr_q.target;
  assign btb_state      = wr_q.state;

  bp_perf_cnt u_br_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (br_res),
    .cnt   (br_cnt)
  );

  bp_perf_cnt u_miss_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (mispredict),
    .cnt   (miss_cnt)
  );

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl with a scoreboard of expected BTB writes.
module tb_btb_ctrl;
  import bp_pkg::*;

  logic               clk;
  logic               reset;
  logic               if_valid;
  logic               if_pred_taken;
  logic [31:0]        if_pred_target;
  logic               id_stall;
  logic               ex_stall;
  logic               ex_valid;
  logic               ex_is_branch;
  logic               ex_br_taken;
  logic [31:0]        ex_pc;
  logic [31:0]        ex_br_target;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               busy;
  logic               btb_we;
  logic [BP_BITS-1:0] btb_idx;
  logic [31:0]        btb_tag;
  logic [31:0]        btb_target;
  logic               btb_state;
  logic [31:0]        br_cnt;
  logic [31:0]        miss_cnt;

  typedef struct {
    logic               we;
    logic [BP_BITS-1:0] idx;
    logic [31:0]        tag;
    logic [31:0]        target;
    logic               st;
  } wr_exp_t;

  wr_exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  btb_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .if_valid       (if_valid),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .id_stall       (id_stall),
    .ex_stall       (ex_stall),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_br_taken    (ex_br_taken),
    .ex_pc          (ex_pc),
    .ex_br_target   (ex_br_target),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy),
    .btb_we         (btb_we),
    .btb_idx        (btb_idx),
    .btb_tag        (btb_tag),
    .btb_target     (btb_target),
    .btb_state      (btb_state),
    .br_cnt         (br_cnt),
    .miss_cnt       (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end
  endtask

  // Pop the oldest expected write and compare it against the BTB port.
  task automatic chk_wr(input string name);
    wr_exp_t e;
    checks++;
    assert (sbq.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=empty_queue expected=entry", name);
    end
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({name, ".we"},     32'(btb_we),     32'(e.we));
      chk({name, ".idx"},    32'(btb_idx),    32'(e.idx));
      chk({name, ".tag"},    btb_tag,         e.tag);
      chk({name, ".target"}, btb_target,      e.target);
      chk({name, ".state"},  32'(btb_state),  32'(e.st));
    end
  endtask

  function automatic wr_exp_t mk(input logic we, input logic [BP_BITS-1:0] idx,
                                 input logic [31:0] tag, input logic [31:0] tgt,
                                 input logic st);
    wr_exp_t e;
    e.we = we; e.idx = idx; e.tag = tag; e.target = tgt; e.st = st;
    return e;
  endfunction

  // Issue one fetch and advance it into EX (two edges, no stalls).
  task automatic issue(input logic pt, input logic [31:0] ptgt);
    if_valid = 1'b1; if_pred_taken = pt; if_pred_target = ptgt;
    @(negedge clk);
    if_valid = 1'b0; if_pred_taken = 1'b0; if_pred_target = '0;
    @(negedge clk);
  endtask

  // Present an EX instruction, check the same-cycle redirect, then the write.
  task automatic run_ex(input string name, input logic is_br, input logic tk,
                        input logic [31:0] pc, input logic [31:0] tgt,
                        input logic exp_rv, input logic [31:0] exp_rpc,
                        input wr_exp_t w);
    ex_valid = 1'b1; ex_is_branch = is_br; ex_br_taken = tk;
    ex_pc = pc; ex_br_target = tgt;
    #1;
    chk({name, ".redirect_valid"}, 32'(redirect_valid), 32'(exp_rv));
    chk({name, ".redirect_pc"}, redirect_pc, exp_rpc);
    sbq.push_back(w);
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    chk_wr({name, ".wr"});
  endtask

  initial begin
    reset = 1'b1;
    if_valid = 1'b0; if_pred_taken = 1'b0; if_pred_target = '0;
    id_stall = 1'b0; ex_stall = 1'b0;
    ex_valid = 1'b0; ex_is_branch = 1'b0; ex_br_taken = 1'b0;
    ex_pc = '0; ex_br_target = '0;

    // Clear sweep, with alias-shaped traffic that must be ignored in INIT.
    @(negedge clk);
    reset = 1'b0;
    if_valid = 1'b1; if_pred_taken = 1'b1; if_pred_target = 32'h40;
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 32'h184;
    for (int i = 0; i < 32; i++) begin
      sbq.push_back(mk(1'b1, BP_BITS'(i), 32'h0, 32'h0, 1'b0));
      #1;
      chk("sweep.busy", 32'(busy), 32'd1);
      chk("sweep.redirect", 32'(redirect_valid), 32'd0);
      chk_wr("sweep");
      if (i == 31) begin
        if_valid = 1'b0; if_pred_taken = 1'b0; ex_valid = 1'b0;
      end
      @(negedge clk);
    end
    #1;
    chk("sweep_end.busy", 32'(busy), 32'd0);
    chk("sweep_end.we", 32'(btb_we), 32'd0);
    chk("sweep_end.br_cnt", br_cnt, 32'd0);
    chk("sweep_end.miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    @(negedge clk);

    // Predicted not-taken, actually taken to 0x80.
    issue(1'b0, 32'h104);
    run_ex("nt_miss", 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80,
           mk(1'b1, 5'd0, 32'h100, 32'h80, 1'b1));
    chk("nt_miss.br_cnt", br_cnt, 32'd1);
    chk("nt_miss.miss_cnt", miss_cnt, 32'd1);

    // Predicted taken to 0x200, actually taken to 0x240.
    issue(1'b1, 32'h200);
    run_ex("tgt_miss", 1'b1, 1'b1, 32'h10C, 32'h240, 1'b1, 32'h240,
           mk(1'b1, 5'd3, 32'h10C, 32'h240, 1'b1));
    chk("tgt_miss.br_cnt", br_cnt, 32'd2);
    chk("tgt_miss.miss_cnt", miss_cnt, 32'd2);

    // Correctly predicted taken.
    issue(1'b1, 32'h80);
    run_ex("hit_t", 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h0,
           mk(1'b1, 5'd0, 32'h100, 32'h80, 1'b1));
    chk("hit_t.br_cnt", br_cnt, 32'd3);
    chk("hit_t.miss_cnt", miss_cnt, 32'd2);

    // Alias: non-branch predicted taken.
    issue(1'b1, 32'h300);
    run_ex("alias", 1'b0, 1'b0, 32'h184, 32'h0, 1'b1, 32'h188,
           mk(1'b1, 5'd1, 32'h0, 32'h0, 1'b0));
    chk("alias.br_cnt", br_cnt, 32'd3);
    chk("alias.miss_cnt", miss_cnt, 32'd3);

    // Correctly predicted not-taken.
    issue(1'b0, 32'h14C);
    run_ex("hit_nt", 1'b1, 1'b0, 32'h148, 32'h400, 1'b0, 32'h0,
           mk(1'b1, 5'd18, 32'h148, 32'h400, 1'b0));
    chk("hit_nt.br_cnt", br_cnt, 32'd4);
    chk("hit_nt.miss_cnt", miss_cnt, 32'd3);

    // Mispredicting branch held in EX by ex_stall for three cycles.
    issue(1'b0, 32'h124);
    ex_stall = 1'b1;
    ex_valid = 1'b1; ex_is_branch = 1'b1; ex_br_taken = 1'b1;
    ex_pc = 32'h120; ex_br_target = 32'h60;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.redirect", 32'(redirect_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("stall.we", 32'(btb_we), 32'd0);
    end
    ex_stall = 1'b0;
    run_ex("stall_rel", 1'b1, 1'b1, 32'h120, 32'h60, 1'b1, 32'h60,
           mk(1'b1, 5'd8, 32'h120, 32'h60, 1'b1));
    ex_valid = 1'b1;
    #1;
    chk("stall_rel.once", 32'(redirect_valid), 32'd0);
    ex_valid = 1'b0;
    chk("stall_rel.br_cnt", br_cnt, 32'd5);
    chk("stall_rel.miss_cnt", miss_cnt, 32'd4);

    // id_stall bubbles ID/EX, then the held fetch resolves as an alias.
    @(negedge clk);
    if_valid = 1'b1; if_pred_taken = 1'b1; if_pred_target = 32'h500;
    @(negedge clk);
    if_valid = 1'b0; if_pred_taken = 1'b0; if_pred_target = '0;
    id_stall = 1'b1;
    @(negedge clk);
    id_stall = 1'b0;
    ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = 32'h200;
    #1;
    chk("id_stall.bubble", 32'(redirect_valid), 32'd0);
    @(negedge clk);
    run_ex("id_stall_alias", 1'b0, 1'b0, 32'h200, 32'h0, 1'b1, 32'h204,
           mk(1'b1, 5'd0, 32'h0, 32'h0, 1'b0));
    chk("id_stall_alias.miss_cnt", miss_cnt, 32'd5);

    // Reset in the middle of a sweep restarts it at index 0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      sbq.push_back(mk(1'b1, BP_BITS'(i), 32'h0, 32'h0, 1'b0));
      #1;
      chk_wr("resweep");
      if (i < 10) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    sbq.push_back(mk(1'b1, 5'd0, 32'h0, 32'h0, 1'b0));
    chk_wr("restart");
    chk("restart.busy", 32'(busy), 32'd1);
    chk("restart.br_cnt", br_cnt, 32'd0);
    chk("restart.miss_cnt", miss_cnt, 32'd0);
    @(negedge clk);
    #1;
    sbq.push_back(mk(1'b1, 5'd1, 32'h0, 32'h0, 1'b0));
    chk_wr("restart_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
